// File: rtl/ring_rand_param.sv
// ring_rand_param: cyclic tone table with a handshaked replay stream and a
// random-access read port. Both readers share one block-RAM read port.
// The table is filled by sequential appends. It is replayed 0..count-1
// endlessly through a small prefetch FIFO.
module ring_rand_param #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 7,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_index,
    output logic              m_last,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    input  logic              rand_en,
    input  logic [ADDR_W-1:0] rand_addr,
    output logic              rand_busy,
    output logic              rand_valid,
    output logic [DATA_W-1:0] rand_data,
    output logic              rand_err
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int FD    = RD_LAT + 1;          // prefetch FIFO depth
    localparam int PW    = $clog2(FD);
    localparam int CW    = $clog2(FD + 1);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic [ADDR_W:0]   count_reg;
    logic              overflow_reg;
    logic [ADDR_W-1:0] rp_reg;
    logic              gen_reg;

    logic [DATA_W-1:0] fifo_data_reg [0:FD-1];
    logic [ADDR_W-1:0] fifo_idx_reg  [0:FD-1];
    logic [PW-1:0]     wp_reg;
    logic [PW-1:0]     rdp_reg;
    logic [CW-1:0]     fcnt_reg;

    logic              rand_busy_reg;
    logic              rand_valid_reg;
    logic [DATA_W-1:0] rand_data_reg;
    logic              rand_err_reg;

    logic              full_w;
    logic              wr_accept;
    logic              restart;
    logic              rand_accept;
    logic              rand_err_w;
    logic              stream_issue;
    logic              inflight;
    logic [ADDR_W-1:0] rd_addr;
    logic              push;
    logic              pop;

    // Signals of the read that completes at this clock edge.
    logic              land_v;
    logic              land_rand;
    logic              land_err;
    logic              land_gen;
    logic [ADDR_W-1:0] land_idx;
    logic [DATA_W-1:0] land_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    // A write, or a clear, restarts the stream. The random port takes priority
    // over stream prefetch for the single RAM read port.
    always_comb begin
        full_w       = (count_reg == (ADDR_W+1)'(DEPTH));
        wr_accept    = wr_en && !full_w && !clear;
        restart      = clear || wr_accept;
        rand_accept  = rand_en && !rand_busy_reg && !restart;
        rand_err_w   = ({1'b0, rand_addr} >= count_reg);
        stream_issue = (count_reg != '0) && !restart && !rand_accept &&
                       ((int'(fcnt_reg) + int'(inflight)) < FD);
        rd_addr      = rand_accept ? rand_addr : rp_reg;
        push         = land_v && !land_rand && (land_gen == gen_reg) && !restart;
        pop          = m_valid && m_ready;
    end

    // Read pipeline. The last stage lands directly in the FIFO or in the random
    // result registers, so the data is visible RD_LAT cycles after the issue.
    generate
        if (RD_LAT == 1) begin : g_lat1
            assign land_v    = stream_issue || rand_accept;
            assign land_rand = rand_accept;
            assign land_err  = rand_err_w;
            assign land_gen  = gen_reg;
            assign land_idx  = rp_reg;
            assign land_data = mem[rd_addr];
            assign inflight  = 1'b0;
        end else begin : g_lat2
            logic              s1_v_reg;
            logic              s1_rand_reg;
            logic              s1_err_reg;
            logic              s1_gen_reg;
            logic [ADDR_W-1:0] s1_idx_reg;
            logic [DATA_W-1:0] ram_q_reg;

            // Registered RAM read. It is not reset, so it maps onto the BRAM read port.
            always_ff @(posedge clk) begin
                ram_q_reg <= mem[rd_addr];
            end

            // The control tag travels alongside the RAM data.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_v_reg    <= 1'b0;
                    s1_rand_reg <= 1'b0;
                    s1_err_reg  <= 1'b0;
                    s1_gen_reg  <= 1'b0;
                    s1_idx_reg  <= '0;
                end else begin
                    s1_v_reg    <= stream_issue || rand_accept;
                    s1_rand_reg <= rand_accept;
                    s1_err_reg  <= rand_err_w;
                    s1_gen_reg  <= gen_reg;
                    s1_idx_reg  <= rp_reg;
                end
            end

            assign land_v    = s1_v_reg;
            assign land_rand = s1_rand_reg;
            assign land_err  = s1_err_reg;
            assign land_gen  = s1_gen_reg;
            assign land_idx  = s1_idx_reg;
            assign land_data = ram_q_reg;
            assign inflight  = s1_v_reg && !s1_rand_reg && (s1_gen_reg == gen_reg);
        end
    endgenerate

    // RAM write port. Writes append at the current fill level.
    always_ff @(posedge clk) begin
        if (wr_accept && !rst) begin
            mem[count_reg[ADDR_W-1:0]] <= din;
        end
    end

    // Fill level, sticky overflow, stream read pointer and restart generation.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            rp_reg       <= '0;
            gen_reg      <= 1'b0;
        end else begin
            if (clear) begin
                count_reg    <= '0;
                overflow_reg <= 1'b0;
            end else if (wr_en) begin
                if (full_w) overflow_reg <= 1'b1;
                else        count_reg    <= count_reg + (ADDR_W+1)'(1);
            end
            if (restart) begin
                rp_reg  <= '0;
                gen_reg <= ~gen_reg;
            end else if (stream_issue) begin
                rp_reg <= ({1'b0, rp_reg} == count_reg - (ADDR_W+1)'(1)) ? '0 : rp_reg + ADDR_W'(1);
            end
        end
    end

    // Prefetch FIFO of {data, index}. A restart flushes it.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            wp_reg   <= '0;
            rdp_reg  <= '0;
            fcnt_reg <= '0;
        end else begin
            if (push) begin
                fifo_data_reg[wp_reg] <= land_data;
                fifo_idx_reg[wp_reg]  <= land_idx;
                wp_reg                <= ptr_inc(wp_reg);
            end
            if (pop) rdp_reg <= ptr_inc(rdp_reg);
            case ({push, pop})
                2'b10:   fcnt_reg <= fcnt_reg + CW'(1);
                2'b01:   fcnt_reg <= fcnt_reg - CW'(1);
                default: fcnt_reg <= fcnt_reg;
            endcase
        end
    end

    // Random read result. rand_valid pulses once, and the data is held until the next result.
    always_ff @(posedge clk) begin
        if (rst) begin
            rand_busy_reg  <= 1'b0;
            rand_valid_reg <= 1'b0;
            rand_data_reg  <= '0;
            rand_err_reg   <= 1'b0;
        end else begin
            rand_valid_reg <= land_v && land_rand;
            if (land_v && land_rand) begin
                rand_data_reg <= land_err ? '0 : land_data;
                rand_err_reg  <= land_err;
            end
            if (rand_accept)         rand_busy_reg <= 1'b1;
            else if (rand_valid_reg) rand_busy_reg <= 1'b0;
        end
    end

    // Stream outputs read zero whenever no word is presented.
    always_comb begin
        m_valid    = (fcnt_reg != '0);
        m_data     = m_valid ? fifo_data_reg[rdp_reg] : '0;
        m_index    = m_valid ? fifo_idx_reg[rdp_reg] : '0;
        m_last     = m_valid && ({1'b0, fifo_idx_reg[rdp_reg]} == count_reg - (ADDR_W+1)'(1));
        count      = count_reg;
        full       = full_w;
        overflow   = overflow_reg;
        rand_busy  = rand_busy_reg;
        rand_valid = rand_valid_reg;
        rand_data  = rand_data_reg;
        rand_err   = rand_err_reg;
    end
endmodule

// File: tb/tb_ring_rand_param.sv
// Directed bench for ring_rand_param. A table model checks every accepted stream beat.
// A scoreboard queue of expected random-read results is pushed at accept and popped on rand_valid.
module tb_ring_rand_param;
    localparam int DATA_W = 14;
    localparam int ADDR_W = 7;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, clear, wr_en, m_ready, rand_en;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] rand_addr;
    logic [DATA_W-1:0] m_data, rand_data;
    logic [ADDR_W-1:0] m_index;
    logic [ADDR_W:0]   count;
    logic              m_valid, m_last, full, overflow, rand_busy, rand_valid, rand_err;

    ring_rand_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .din(din),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_index(m_index),
        .m_last(m_last), .count(count), .full(full), .overflow(overflow),
        .rand_en(rand_en), .rand_addr(rand_addr), .rand_busy(rand_busy),
        .rand_valid(rand_valid), .rand_data(rand_data), .rand_err(rand_err)
    );

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
        logic              err;
    } rexp_t;

    rexp_t             rq[$];
    logic [DATA_W-1:0] model_mem [0:DEPTH-1];
    int                model_count, exp_idx;
    logic              model_ovf;
    int                cyc, checks, errors;

    logic              s_valid, s_last, s_rvalid;
    logic [DATA_W-1:0] s_data;
    logic [ADDR_W-1:0] s_index;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle. The task samples at the falling edge and checks against the
    // model, then applies this cycle's inputs to the model.
    task automatic step();
        logic  busy_m, restart;
        rexp_t e;
        @(negedge clk);
        cyc++;
        s_valid = m_valid; s_data = m_data; s_index = m_index; s_last = m_last; s_rvalid = rand_valid;
        busy_m = (rq.size() != 0);
        check("count", 32'(count), 32'(model_count));
        check("full", 32'(full), 32'(model_count == DEPTH));
        check("overflow", 32'(overflow), 32'(model_ovf));
        check("rand_busy", 32'(rand_busy), 32'(busy_m));
        if (rand_valid) begin
            if (rq.size() == 0) begin
                check("rand_valid_unexpected", 32'(rand_valid), 32'(0));
            end else begin
                e = rq.pop_front();
                check("rand_latency", 32'(cyc), 32'(e.due));
                check("rand_data", 32'(rand_data), 32'(e.data));
                check("rand_err", 32'(rand_err), 32'(e.err));
            end
        end else if (rq.size() != 0 && rq[0].due <= cyc) begin
            e = rq.pop_front();
            check("rand_valid_missing", 32'(rand_valid), 32'(1));
        end
        if (model_count == 0) begin
            check("m_valid_empty", 32'(m_valid), 32'(0));
        end else if (m_valid && m_ready) begin
            check("m_index", 32'(m_index), 32'(exp_idx));
            check("m_data", 32'(m_data), 32'(model_mem[exp_idx]));
            check("m_last", 32'(m_last), 32'(exp_idx == model_count - 1));
            exp_idx = (exp_idx == model_count - 1) ? 0 : exp_idx + 1;
        end
        restart = 1'b0;
        if (rst) begin
            model_count = 0; model_ovf = 1'b0; exp_idx = 0;
            rq.delete();
        end else begin
            if (clear) begin
                model_count = 0; model_ovf = 1'b0; restart = 1'b1;
            end else if (wr_en) begin
                if (model_count == DEPTH) model_ovf = 1'b1;
                else begin
                    model_mem[model_count] = din;
                    model_count++;
                    restart = 1'b1;
                end
            end
            if (restart) exp_idx = 0;
            if (rand_en && !busy_m && !restart) begin
                e.due  = cyc + RD_LAT;
                e.err  = (int'(rand_addr) >= model_count);
                e.data = e.err ? '0 : model_mem[rand_addr];
                rq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic write_word(input logic [DATA_W-1:0] d);
        wr_en = 1'b1; din = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rand_rd(input logic [ADDR_W-1:0] a);
        rand_en = 1'b1; rand_addr = a;
        step();
        rand_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, 32'(m_valid), 32'(0));
        check({tag, "_m_data"}, 32'(m_data), 32'(0));
        check({tag, "_m_index"}, 32'(m_index), 32'(0));
        check({tag, "_m_last"}, 32'(m_last), 32'(0));
        check({tag, "_count"}, 32'(count), 32'(0));
        check({tag, "_full"}, 32'(full), 32'(0));
        check({tag, "_overflow"}, 32'(overflow), 32'(0));
        check({tag, "_rand_busy"}, 32'(rand_busy), 32'(0));
        check({tag, "_rand_valid"}, 32'(rand_valid), 32'(0));
        check({tag, "_rand_data"}, 32'(rand_data), 32'(0));
        check({tag, "_rand_err"}, 32'(rand_err), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] h_data;
        logic [ADDR_W-1:0] h_index;
        logic              h_last, found;
        int                bubbles;

        rst = 1'b1; clear = 1'b0; wr_en = 1'b0; din = '0; m_ready = 1'b0;
        rand_en = 1'b0; rand_addr = '0;
        cyc = 0; checks = 0; errors = 0;
        model_count = 0; exp_idx = 0; model_ovf = 1'b0;

        // Reset state
        idle(2);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Five words, then the stream starts 3 cycles after the last write with no bubbles
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) write_word(DATA_W'(16'h100 + i));
        step(); check("lat_t1_valid", 32'(s_valid), 32'(0));
        step(); check("lat_t2_valid", 32'(s_valid), 32'(0));
        step(); check("lat_t3_valid", 32'(s_valid), 32'(1));
        check("lat_t3_index", 32'(s_index), 32'(0));
        check("lat_t3_data", 32'(s_data), 32'(16'h100));
        for (int i = 0; i < 12; i++) begin
            step(); check("no_bubble", 32'(s_valid), 32'(1));
        end

        // Backpressure: the presented word holds steady for 10 cycles
        m_ready = 1'b0;
        step();
        h_data = s_data; h_index = s_index; h_last = s_last;
        check("hold_valid", 32'(s_valid), 32'(1));
        for (int i = 0; i < 9; i++) begin
            step();
            check("hold_valid", 32'(s_valid), 32'(1));
            check("hold_data", 32'(s_data), 32'(h_data));
            check("hold_index", 32'(s_index), 32'(h_index));
            check("hold_last", 32'(s_last), 32'(h_last));
        end
        m_ready = 1'b1;
        idle(12);

        // Random read during streaming costs at most one bubble
        rand_rd(7'd3);
        bubbles = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (!s_valid) bubbles++;
        end
        check("rand_bubbles_le1", 32'(bubbles <= 1), 32'(1));
        check("rand_data_held", 32'(rand_data), 32'(16'h103));
        rand_rd(7'd7);
        idle(4);
        check("rand_oob_err", 32'(rand_err), 32'(1));
        check("rand_oob_data", 32'(rand_data), 32'(0));

        // Fill to DEPTH, then one write too many
        clear = 1'b1; step(); clear = 1'b0;
        for (int i = 0; i < DEPTH; i++) write_word(DATA_W'(16'h200 + i));
        write_word(DATA_W'(16'h3fff));
        idle(1);
        check("fill_count", 32'(count), 32'(DEPTH));
        check("fill_full", 32'(full), 32'(1));
        check("fill_overflow", 32'(overflow), 32'(1));
        rand_rd(7'd0);
        idle(4);
        check("no_wrap_write", 32'(rand_data), 32'(16'h200));
        clear = 1'b1; step(); clear = 1'b0;
        step();
        check("clear_count", 32'(count), 32'(0));
        check("clear_overflow", 32'(overflow), 32'(0));
        check("clear_m_valid", 32'(s_valid), 32'(0));
        idle(5);
        rand_rd(7'd0);
        idle(4);
        check("empty_rand_err", 32'(rand_err), 32'(1));

        // Append while index 2 of a 3-entry loop is presented
        for (int i = 0; i < 3; i++) write_word(DATA_W'(16'h50 + i));
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (s_valid && s_index == 1) found = 1'b1;
        end
        check("wait_index1", 32'(found), 32'(1));
        write_word(DATA_W'(16'h53));
        check("append_at_index", 32'(s_index), 32'(2));
        step(); check("restart_drop", 32'(s_valid), 32'(0));
        step(); check("restart_t2", 32'(s_valid), 32'(0));
        step(); check("restart_t3", 32'(s_valid), 32'(1));
        check("restart_index", 32'(s_index), 32'(0));
        idle(12);

        // Reset during an outstanding random read and a live beat
        rand_rd(7'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_during_beat", 32'(s_valid), 32'(1));
        check_reset_outputs("mid_rst");
        step();
        check("rst_suppress_rvalid", 32'(s_rvalid), 32'(0));
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
